// File: rtl/rv_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control unit.
package rv_ctrl_pkg;

  // Control FSM states.
  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWb,
    StTrap
  } state_e;

  // Instruction class resolved by the decoder.
  typedef enum logic [3:0] {
    OpIllegal,
    OpR,
    OpI,
    OpLoad,
    OpStore,
    OpBranch,
    OpLui,
    OpAuipc,
    OpJal,
    OpJalr
  } op_class_e;

  // RV32I major opcodes.
  localparam logic [6:0] OP_TYPE_R     = 7'b0110011;
  localparam logic [6:0] OP_TYPE_I     = 7'b0010011;
  localparam logic [6:0] OP_TYPE_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_TYPE_STORE = 7'b0100011;
  localparam logic [6:0] OP_TYPE_B     = 7'b1100011;
  localparam logic [6:0] OP_TYPE_LUI   = 7'b0110111;
  localparam logic [6:0] OP_TYPE_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_TYPE_JAL   = 7'b1101111;
  localparam logic [6:0] OP_TYPE_JALR  = 7'b1100111;

  // funct7 values that matter for legality.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ALU control encodings: {mExt, instr[30], funct3}.
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b01000;

  // Register-file write-data source select.
  localparam logic [2:0] RFWD_ALU   = 3'b000;
  localparam logic [2:0] RFWD_LOAD  = 3'b001;
  localparam logic [2:0] RFWD_PC4   = 3'b010;
  localparam logic [2:0] RFWD_IMM   = 3'b011;
  localparam logic [2:0] RFWD_PCIMM = 3'b100;

endpackage

// File: rtl/rv_ctrl_decoder.sv
// Combinational instruction-field decode and legality check.
// RV32M_EN: when defined, R-type funct7=0000001 (M extension) is legal.
module rv_ctrl_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output op_class_e  op_class,
  output logic       legal,
  output logic       alu_src,
  output logic [2:0] rfwd_sel,
  output logic [4:0] alu_ctrl,
  output logic       is_jal,
  output logic       is_jalr
);

  // Classify the opcode and derive datapath fields; unknown encodings stay illegal.
  always_comb begin
    op_class = OpIllegal;
    legal    = 1'b0;
    alu_src  = 1'b0;
    rfwd_sel = RFWD_ALU;
    alu_ctrl = ALU_ADD;
    is_jal   = 1'b0;
    is_jalr  = 1'b0;
    case (opcode)
      OP_TYPE_R: begin
        op_class = OpR;
        if (funct7 == F7_BASE) begin
          legal    = 1'b1;
          alu_ctrl = {2'b00, funct3};
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          legal    = 1'b1;
          alu_ctrl = {2'b01, funct3};
        end
`ifdef RV32M_EN
        else if (funct7 == F7_MULDIV) begin
          legal    = 1'b1;
          alu_ctrl = {2'b10, funct3};
        end
`endif
      end
      OP_TYPE_I: begin
        op_class = OpI;
        alu_src  = 1'b1;
        // Only shifts carry funct7; SRAI is the sole user of bit 30.
        alu_ctrl = {1'b0, (funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
        if (funct3 == 3'b001)      legal = (funct7 == F7_BASE);
        else if (funct3 == 3'b101) legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        else                       legal = 1'b1;
      end
      OP_TYPE_LOAD: begin
        op_class = OpLoad;
        alu_src  = 1'b1;
        rfwd_sel = RFWD_LOAD;
        legal    = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b101);
      end
      OP_TYPE_STORE: begin
        op_class = OpStore;
        alu_src  = 1'b1;
        legal    = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end
      OP_TYPE_B: begin
        op_class = OpBranch;
        alu_ctrl = {2'b00, funct3};
        legal    = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OP_TYPE_LUI: begin
        op_class = OpLui;
        rfwd_sel = RFWD_IMM;
        legal    = 1'b1;
      end
      OP_TYPE_AUIPC: begin
        op_class = OpAuipc;
        rfwd_sel = RFWD_PCIMM;
        legal    = 1'b1;
      end
      OP_TYPE_JAL: begin
        op_class = OpJal;
        rfwd_sel = RFWD_PC4;
        is_jal   = 1'b1;
        legal    = 1'b1;
      end
      OP_TYPE_JALR: begin
        op_class = OpJalr;
        alu_src  = 1'b1;
        rfwd_sel = RFWD_PC4;
        is_jalr  = 1'b1;
        legal    = (funct3 == 3'b000);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXECUTE/MEM/WB/TRAP sequencer for a
// shared-bus datapath, with bus wait states, bus timeout, illegal-op trap and retire pulse.
// RV32M_EN: when defined, M-extension R-type instructions are accepted.
module multi_cycle_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        busReady,
  output logic        pcEn,
  output logic        irWe,
  output logic        busAddrSel,
  output logic        busRe,
  output logic        busWe,
  output logic        regFileWe,
  output logic        aluSrcMuxSel,
  output logic [4:0]  aluControl,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        JAL,
  output logic        JALR,
  output logic        retire,
  output logic        trap
);

  // Width kept at least 1 so BUS_TIMEOUT=0 (timeout disabled) still elaborates.
  localparam int unsigned TO_W = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            timeout_hit;

  op_class_e  dec_class;
  logic       dec_legal;
  logic       dec_alu_src;
  logic [2:0] dec_rfwd;
  logic [4:0] dec_alu;
  logic       dec_jal;
  logic       dec_jalr;
  logic       unused_instr;

  assign unused_instr = ^{instrCode[24:15], instrCode[11:7]};

  rv_ctrl_decoder u_decoder (
    .opcode   (instrCode[6:0]),
    .funct3   (instrCode[14:12]),
    .funct7   (instrCode[31:25]),
    .op_class (dec_class),
    .legal    (dec_legal),
    .alu_src  (dec_alu_src),
    .rfwd_sel (dec_rfwd),
    .alu_ctrl (dec_alu),
    .is_jal   (dec_jal),
    .is_jalr  (dec_jalr)
  );

  // Last permitted wait cycle: busReady here still succeeds, otherwise trap next.
  assign timeout_hit = (BUS_TIMEOUT != 0) && (cnt_q == TO_W'(BUS_TIMEOUT - 1));

  // State and timeout counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, strobe and field decode; strobes are squashed while reset is high.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pcEn          = 1'b0;
    irWe          = 1'b0;
    busAddrSel    = 1'b0;
    busRe         = 1'b0;
    busWe         = 1'b0;
    regFileWe     = 1'b0;
    branch        = 1'b0;
    retire        = 1'b0;
    trap          = 1'b0;
    aluSrcMuxSel  = 1'b0;
    RFWDSrcMuxSel = RFWD_ALU;
    aluControl    = ALU_ADD;
    JAL           = 1'b0;
    JALR          = 1'b0;

    if (state_q inside {StDecode, StExecute, StMem, StWb}) begin
      aluSrcMuxSel  = dec_alu_src;
      RFWDSrcMuxSel = dec_rfwd;
      aluControl    = dec_alu;
      JAL           = dec_jal;
      JALR          = dec_jalr;
    end

    unique case (state_q)
      StFetch: begin
        busRe = 1'b1;
        if (busReady) begin
          irWe    = 1'b1;
          state_d = StDecode;
        end else if (timeout_hit) begin
          state_d = StTrap;
        end else if (BUS_TIMEOUT != 0) begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      StDecode: begin
        state_d = dec_legal ? StExecute : StTrap;
      end
      StExecute: begin
        case (dec_class)
          OpLoad, OpStore: state_d = StMem;
          OpBranch: begin
            branch  = 1'b1;
            pcEn    = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end
          default: begin
            regFileWe = 1'b1;
            pcEn      = 1'b1;
            retire    = 1'b1;
            state_d   = StFetch;
          end
        endcase
      end
      StMem: begin
        busAddrSel = 1'b1;
        if (dec_class == OpStore) busWe = 1'b1;
        else                      busRe = 1'b1;
        if (busReady) begin
          if (dec_class == OpStore) begin
            pcEn    = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (timeout_hit) begin
          state_d = StTrap;
        end else if (BUS_TIMEOUT != 0) begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      StWb: begin
        regFileWe = 1'b1;
        pcEn      = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StTrap: begin
        trap = 1'b1;
      end
      default: begin
        state_d = StTrap;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;

    if (reset) begin
      pcEn       = 1'b0;
      irWe       = 1'b0;
      busAddrSel = 1'b0;
      busRe      = 1'b0;
      busWe      = 1'b0;
      regFileWe  = 1'b0;
      branch     = 1'b0;
      retire     = 1'b0;
      trap       = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed self-checking bench for multi_cycle_control_unit.
module tb_multi_cycle_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] instrCode;
  logic        busReady;
  logic        pcEn, irWe, busAddrSel, busRe, busWe, regFileWe, aluSrcMuxSel;
  logic [4:0]  aluControl;
  logic [2:0]  RFWDSrcMuxSel;
  logic        branch, JAL, JALR, retire, trap;

  int compared;
  int mismatched;

  // Strobe bundle bits.
  localparam logic [8:0] S_PC = 9'h100;
  localparam logic [8:0] S_IR = 9'h080;
  localparam logic [8:0] S_AS = 9'h040;
  localparam logic [8:0] S_RE = 9'h020;
  localparam logic [8:0] S_WE = 9'h010;
  localparam logic [8:0] S_RF = 9'h008;
  localparam logic [8:0] S_BR = 9'h004;
  localparam logic [8:0] S_RT = 9'h002;
  localparam logic [8:0] S_TR = 9'h001;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRAI = 32'h4030D093;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_MUL  = 32'h022081B3;

  logic [8:0]  strobes;
  logic [10:0] fields;
  assign strobes = {pcEn, irWe, busAddrSel, busRe, busWe, regFileWe, branch, retire, trap};
  assign fields  = {aluSrcMuxSel, RFWDSrcMuxSel, JAL, JALR, aluControl};

  multi_cycle_control_unit #(.BUS_TIMEOUT(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .instrCode     (instrCode),
    .busReady      (busReady),
    .pcEn          (pcEn),
    .irWe          (irWe),
    .busAddrSel    (busAddrSel),
    .busRe         (busRe),
    .busWe         (busWe),
    .regFileWe     (regFileWe),
    .aluSrcMuxSel  (aluSrcMuxSel),
    .aluControl    (aluControl),
    .RFWDSrcMuxSel (RFWDSrcMuxSel),
    .branch        (branch),
    .JAL           (JAL),
    .JALR          (JALR),
    .retire        (retire),
    .trap          (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the FSM in its first FETCH cycle.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    busReady  = 1'b1;
    instrCode = I_ADD;
    @(posedge clk);
    @(negedge clk);
    compared++;
    if (strobes !== 9'h000) begin
      mismatched++;
      $display("FAIL reset_strobes: got %h want %h", strobes, 9'h000);
    end
    #1 reset = 1'b0;
    busReady = 1'b0;
    next_cycle();
    @(negedge clk);
    compared++;
    if (strobes !== S_RE) begin
      mismatched++;
      $display("FAIL reset_fetch_strobes: got %h want %h", strobes, S_RE);
    end
    compared++;
    if (fields !== 11'h000) begin
      mismatched++;
      $display("FAIL reset_fetch_fields: got %h want %h", fields, 11'h000);
    end
  endtask

  // Back-to-back single-EXECUTE instructions, each fetched with zero wait.
  task automatic test_exec_classes();
    logic [31:0] instr [7];
    logic [8:0]  exp_s [7];
    logic [10:0] exp_f [7];
    instr = '{I_ADD, I_SUB, I_SRAI, I_BEQ, I_JAL, I_LUI, I_ADD};
    exp_s = '{S_PC | S_RF | S_RT, S_PC | S_RF | S_RT, S_PC | S_RF | S_RT, S_PC | S_BR | S_RT,
              S_PC | S_RF | S_RT, S_PC | S_RF | S_RT, S_PC | S_RF | S_RT};
    exp_f = '{11'h000, 11'h008, 11'h40D, 11'h000, 11'h140, 11'h180, 11'h000};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      instrCode = instr[k];
      busReady  = 1'b1;
      @(negedge clk);
      compared++;
      if (strobes !== (S_IR | S_RE)) begin
        mismatched++;
        $display("FAIL exec%0d_fetch: got %h want %h", k, strobes, S_IR | S_RE);
      end
      next_cycle();
      busReady = 1'b0;
      @(negedge clk);
      compared++;
      if (strobes !== 9'h000 || fields !== exp_f[k]) begin
        mismatched++;
        $display("FAIL exec%0d_decode: got %h/%h want %h/%h", k, strobes, fields, 9'h000,
                 exp_f[k]);
      end
      next_cycle();
      @(negedge clk);
      compared++;
      if (strobes !== exp_s[k] || fields !== exp_f[k]) begin
        mismatched++;
        $display("FAIL exec%0d_execute: got %h/%h want %h/%h", k, strobes, fields, exp_s[k],
                 exp_f[k]);
      end
      next_cycle();
    end
  endtask

  // LW with two MEM wait cycles: WB lands in cycle 7.
  task automatic test_load_wait();
    logic       rdy   [8];
    logic [8:0] exp_s [8];
    logic [10:0] exp_f [8];
    rdy   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_s = '{S_IR | S_RE, 9'h000, 9'h000, S_AS | S_RE, S_AS | S_RE, S_AS | S_RE,
              S_PC | S_RF | S_RT, S_RE};
    exp_f = '{11'h000, 11'h480, 11'h480, 11'h480, 11'h480, 11'h480, 11'h480, 11'h000};
    do_reset();
    instrCode = I_LW;
    for (int c = 0; c < 8; c++) begin
      busReady = rdy[c];
      @(negedge clk);
      compared++;
      if (strobes !== exp_s[c] || fields !== exp_f[c]) begin
        mismatched++;
        $display("FAIL lw_cycle%0d: got %h/%h want %h/%h", c + 1, strobes, fields, exp_s[c],
                 exp_f[c]);
      end
      next_cycle();
    end
  endtask

  // SW with zero wait: retire in cycle 4, never a register write.
  task automatic test_store();
    logic       rdy   [5];
    logic [8:0] exp_s [5];
    logic       rf_seen;
    rdy     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_s   = '{S_IR | S_RE, 9'h000, 9'h000, S_AS | S_WE | S_PC | S_RT, S_RE};
    rf_seen = 1'b0;
    do_reset();
    instrCode = I_SW;
    for (int c = 0; c < 5; c++) begin
      busReady = rdy[c];
      @(negedge clk);
      rf_seen = rf_seen | regFileWe;
      compared++;
      if (strobes !== exp_s[c]) begin
        mismatched++;
        $display("FAIL sw_cycle%0d: got %h want %h", c + 1, strobes, exp_s[c]);
      end
      next_cycle();
    end
    compared++;
    if (rf_seen !== 1'b0) begin
      mismatched++;
      $display("FAIL sw_no_regwrite: got %b want %b", rf_seen, 1'b0);
    end
  endtask

  // busReady never arrives: 16 FETCH cycles, then sticky trap until reset.
  task automatic test_timeout();
    int bad_fetch;
    do_reset();
    instrCode = I_ADD;
    busReady  = 1'b0;
    bad_fetch = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (strobes !== S_RE) bad_fetch++;
      next_cycle();
    end
    compared++;
    if (bad_fetch !== 0) begin
      mismatched++;
      $display("FAIL timeout_wait_cycles: got %0d bad cycles want 0", bad_fetch);
    end
    busReady = 1'b1;
    for (int c = 17; c <= 20; c++) begin
      @(negedge clk);
      compared++;
      if (strobes !== S_TR || fields !== 11'h000) begin
        mismatched++;
        $display("FAIL timeout_trap_c%0d: got %h/%h want %h/%h", c, strobes, fields, S_TR,
                 11'h000);
      end
      next_cycle();
    end
    do_reset();
    busReady = 1'b0;
    @(negedge clk);
    compared++;
    if (strobes !== S_RE) begin
      mismatched++;
      $display("FAIL timeout_reset_clears: got %h want %h", strobes, S_RE);
    end
  endtask

  // busReady on the last permitted wait cycle still completes the fetch.
  task automatic test_timeout_edge();
    do_reset();
    instrCode = I_ADD;
    busReady  = 1'b0;
    for (int c = 1; c <= 15; c++) next_cycle();
    busReady = 1'b1;
    @(negedge clk);
    compared++;
    if (strobes !== (S_IR | S_RE)) begin
      mismatched++;
      $display("FAIL timeout_edge_fetch: got %h want %h", strobes, S_IR | S_RE);
    end
    next_cycle();
    busReady = 1'b0;
    @(negedge clk);
    compared++;
    if (strobes !== 9'h000) begin
      mismatched++;
      $display("FAIL timeout_edge_decode: got %h want %h", strobes, 9'h000);
    end
    next_cycle();
    @(negedge clk);
    compared++;
    if (strobes !== (S_PC | S_RF | S_RT)) begin
      mismatched++;
      $display("FAIL timeout_edge_exec: got %h want %h", strobes, S_PC | S_RF | S_RT);
    end
  endtask

  // Runs FETCH/DECODE and checks the cycle after DECODE.
  task automatic test_illegal();
    logic [31:0] instr [2];
    logic [8:0]  exp_s [2];
    logic [10:0] exp_f [2];
    instr = '{32'h00000000, I_MUL};
`ifdef RV32M_EN
    exp_s = '{S_TR, S_PC | S_RF | S_RT};
    exp_f = '{11'h000, 11'h010};
`else
    exp_s = '{S_TR, S_TR};
    exp_f = '{11'h000, 11'h000};
`endif
    for (int k = 0; k < 2; k++) begin
      do_reset();
      instrCode = instr[k];
      busReady  = 1'b1;
      next_cycle();
      busReady = 1'b0;
      next_cycle();
      @(negedge clk);
      compared++;
      if (strobes !== exp_s[k] || fields !== exp_f[k]) begin
        mismatched++;
        $display("FAIL illegal%0d_after_decode: got %h/%h want %h/%h", k, strobes, fields,
                 exp_s[k], exp_f[k]);
      end
    end
  endtask

  // Reset pulse while a store waits in MEM.
  task automatic test_reset_mid_mem();
    do_reset();
    instrCode = I_SW;
    busReady  = 1'b1;
    next_cycle();
    busReady = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    compared++;
    if (strobes !== (S_AS | S_WE)) begin
      mismatched++;
      $display("FAIL midmem_before: got %h want %h", strobes, S_AS | S_WE);
    end
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if (strobes !== 9'h000) begin
      mismatched++;
      $display("FAIL midmem_during_reset: got %h want %h", strobes, 9'h000);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (strobes !== S_RE || fields !== 11'h000) begin
      mismatched++;
      $display("FAIL midmem_after_reset: got %h/%h want %h/%h", strobes, fields, S_RE,
               11'h000);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    busReady   = 1'b0;
    instrCode  = 32'h0;
    test_reset();
    test_exec_classes();
    test_load_wait();
    test_store();
    test_timeout();
    test_timeout_edge();
    test_illegal();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard stop in case the sequence above stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
